// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Receives a program image from a host byte stream and writes it into an
// instruction memory while holding the CPU in reset.
//
// Stream format for one load session (after a start pulse):
//   byte 0          : len, the number of instruction bytes that follow
//   bytes 1..len    : instruction bytes, written to addresses 0..len-1
//   byte len+1      : checksum = (len + all instruction bytes) mod 256
//
// A session ends in DONE when the checksum matches, which releases the CPU
// from reset. It ends in ERR on a checksum mismatch or when len exceeds
// MAX_LEN, which keeps the CPU in reset.
//
// Parameters:
//   MAX_LEN   largest instruction count accepted in one session
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   reset      synchronous active-high reset
//   start      one-cycle pulse that begins a session (IDLE/DONE/ERR only)
//   in_data    host byte
//   in_valid   in_data is valid this cycle
//   in_ready   loader accepts in_data this cycle (LEN, DATA, CHECK)
//   ins_write  instruction-memory write strobe
//   ins_addr   instruction-memory write address
//   ins_data   instruction-memory write data
//   cpu_reset  holds the CPU in reset while high (low only in DONE)
//   busy       a session is in progress
//   done       last session loaded with a good checksum
//   error      last session failed its checksum or length check
//   count      instruction bytes written in the current or last session
// ---------------------------------------------------------------------------
module program_loader #(
  parameter logic [7:0] MAX_LEN = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ins_write,
  output logic [7:0] ins_addr,
  output logic [7:0] ins_data,
  output logic       cpu_reset,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] count
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] len;
  logic [7:0] acc;
  logic       accept;
  logic       len_too_long;
  logic       last_data;

  // The loader listens to the host only while a session is running; the
  // same decode doubles as the busy indication.
  assign in_ready = (state == LEN) || (state == DATA) || (state == CHECK);
  assign busy     = in_ready;
  assign accept   = in_valid && in_ready;

  // Compared one bit wider so a MAX_LEN of 255 simply never trips the check
  // rather than producing a comparison that is constant at elaboration.
  assign len_too_long = ({1'b0, in_data} > {1'b0, MAX_LEN});

  // count equals the index of the byte being accepted, because it advances
  // on every DATA acceptance; the final instruction byte has index len-1.
  assign last_data = (count == (len - 8'd1));

  // Next-state decode. start only matters between sessions, and every
  // in-session transition waits for an accepted byte so idle host cycles
  // leave the FSM where it is.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          next_state = LEN;
        end
      end
      LEN: begin
        if (accept) begin
          if (in_data == 8'd0) begin
            next_state = CHECK;
          end else if (len_too_long) begin
            next_state = ERR;
          end else begin
            next_state = DATA;
          end
        end
      end
      DATA: begin
        if (accept && last_data) begin
          next_state = CHECK;
        end
      end
      CHECK: begin
        if (accept) begin
          next_state = (in_data == acc) ? DONE : ERR;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register and datapath. The status outputs are registered copies
  // of the next state, so they line up with the state register exactly.
  // The memory write for a DATA byte is registered at the acceptance edge,
  // which puts the strobe in the following cycle with the pre-increment
  // address while count advances at that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      len       <= 8'd0;
      acc       <= 8'd0;
      count     <= 8'd0;
      ins_write <= 1'b0;
      ins_addr  <= 8'd0;
      ins_data  <= 8'd0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      state     <= next_state;
      ins_write <= 1'b0;
      done      <= (next_state == DONE);
      error     <= (next_state == ERR);
      cpu_reset <= (next_state != DONE);
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            count <= 8'd0;
            acc   <= 8'd0;
            len   <= 8'd0;
          end
        end
        LEN: begin
          if (accept) begin
            len <= in_data;
            acc <= acc + in_data;
          end
        end
        DATA: begin
          if (accept) begin
            acc       <= acc + in_data;
            ins_write <= 1'b1;
            ins_addr  <= count;
            ins_data  <= in_data;
            count     <= count + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader. Expected writes and final status
// come from a session-level model that reads the byte stream directly:
// first byte is the length, the following bytes are the program, the last
// byte is the checksum of everything before it.
// ---------------------------------------------------------------------------
module tb_program_loader;

  localparam logic [7:0] TB_MAX_LEN = 8'd16;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ins_write;
  logic [7:0] ins_addr;
  logic [7:0] ins_data;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         wr_cyc_q[$];

  logic [7:0] exp_addr[$];
  logic [7:0] exp_data[$];
  logic       exp_done;
  logic       exp_error;
  logic [7:0] exp_count;

  program_loader #(.MAX_LEN(TB_MAX_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ins_write (ins_write),
    .ins_addr  (ins_addr),
    .ins_data  (ins_data),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .count     (count)
  );

  // Free-running clock and cycle counter used to time-stamp writes.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every memory write strobe away from the rising edge.
  always @(negedge clk) begin
    if (ins_write === 1'b1) begin
      wr_addr_q.push_back(ins_addr);
      wr_data_q.push_back(ins_data);
      wr_cyc_q.push_back(cyc);
    end
  end

  // Session-level model of the expected outcome of one byte stream.
  task automatic model_session(input bq_t b);
    int len;
    int sum;
    exp_addr.delete();
    exp_data.delete();
    len = int'(b[0]);
    sum = len;
    if (len > int'(TB_MAX_LEN)) begin
      exp_done  = 1'b0;
      exp_error = 1'b1;
      exp_count = 8'd0;
      return;
    end
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(8'(i));
      exp_data.push_back(b[1 + i]);
      sum = sum + int'(b[1 + i]);
    end
    exp_count = 8'(len);
    exp_done  = (int'(b[len + 1]) == (sum % 256));
    exp_error = !exp_done;
  endtask

  // Build a random session; the checksum is usually right.
  task automatic build_random(output bq_t b, input int max_len);
    int len;
    int sum;
    b.delete();
    len = $urandom_range(max_len, 0);
    sum = len;
    b.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      b.push_back(8'($urandom));
      sum = sum + int'(b[i + 1]);
    end
    if ($urandom_range(3, 0) != 0) begin
      b.push_back(8'(sum));
    end else begin
      b.push_back(8'(sum) ^ 8'($urandom_range(255, 1)));
    end
  endtask

  // Drive start then the byte stream; optionally idle one cycle after each
  // byte past the length byte.
  task automatic drive_session(input bq_t b, input bit gaps);
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    foreach (b[i]) begin
      in_valid = 1'b1;
      in_data  = b[i];
      @(negedge clk);
      if (gaps && i >= 1) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reset wins over start and a valid byte presented in the same cycles.
  task automatic test_reset();
    @(negedge clk);
    reset    = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h05;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, busy, cpu_reset, done, error, ins_write} !== 6'b001000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b expected 001000",
               {in_ready, busy, cpu_reset, done, error, ins_write});
    end
    total++;
    if ({count, ins_addr, ins_data} !== 24'h0) begin
      bad++;
      $display("[TB] FAIL reset_regs: got %h expected 000000", {count, ins_addr, ins_data});
    end
    start    = 1'b0;
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release_idle: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_good_load();
    bq_t b;
    b = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
    model_session(b);
    drive_session(b, 1'b0);
    total++;
    if (wr_addr_q.size() !== 3) begin
      bad++;
      $display("[TB] FAIL good_nwrites: got %0d expected 3", wr_addr_q.size());
    end
    for (int i = 0; i < wr_addr_q.size() && i < exp_addr.size(); i++) begin
      total++;
      if ({wr_addr_q[i], wr_data_q[i]} !== {exp_addr[i], exp_data[i]}) begin
        bad++;
        $display("[TB] FAIL good_write%0d: got %h/%h expected %h/%h", i,
                 wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
      end
    end
    for (int i = 1; i < wr_cyc_q.size(); i++) begin
      total++;
      if (wr_cyc_q[i] - wr_cyc_q[i - 1] !== 1) begin
        bad++;
        $display("[TB] FAIL good_consecutive%0d: got gap %0d expected 1", i,
                 wr_cyc_q[i] - wr_cyc_q[i - 1]);
      end
    end
    total++;
    if ({done, error, cpu_reset, busy, count} !== {4'b1000, 8'd3}) begin
      bad++;
      $display("[TB] FAIL good_status: got d%b e%b r%b b%b c%0d expected d1 e0 r0 b0 c3",
               done, error, cpu_reset, busy, count);
    end
  endtask

  task automatic test_bad_checksum();
    bq_t b;
    b = '{8'h02, 8'hAA, 8'h55, 8'h00};
    drive_session(b, 1'b0);
    total++;
    if (wr_addr_q.size() !== 2) begin
      bad++;
      $display("[TB] FAIL badck_nwrites: got %0d expected 2", wr_addr_q.size());
    end
    total++;
    if (wr_addr_q.size() == 2 &&
        {wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]} !== 32'h00AA_0155) begin
      bad++;
      $display("[TB] FAIL badck_writes: got %h expected 00aa0155",
               {wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]});
    end
    total++;
    if ({done, error, cpu_reset} !== 3'b011) begin
      bad++;
      $display("[TB] FAIL badck_status: got d%b e%b r%b expected d0 e1 r1",
               done, error, cpu_reset);
    end
  endtask

  task automatic test_zero_length();
    bq_t b;
    b = '{8'h00, 8'h00};
    drive_session(b, 1'b0);
    total++;
    if (wr_addr_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL zero_nwrites: got %0d expected 0", wr_addr_q.size());
    end
    total++;
    if ({done, error, cpu_reset, count} !== {3'b100, 8'd0}) begin
      bad++;
      $display("[TB] FAIL zero_status: got d%b e%b r%b c%0d expected d1 e0 r0 c0",
               done, error, cpu_reset, count);
    end
  endtask

  task automatic test_gaps();
    bq_t b;
    int sum;
    b   = '{8'h04};
    sum = 4;
    for (int i = 0; i < 4; i++) begin
      b.push_back(8'($urandom));
      sum = sum + int'(b[i + 1]);
    end
    b.push_back(8'(sum));
    model_session(b);
    drive_session(b, 1'b1);
    total++;
    if (wr_addr_q.size() !== exp_addr.size()) begin
      bad++;
      $display("[TB] FAIL gaps_nwrites: got %0d expected %0d", wr_addr_q.size(), exp_addr.size());
    end
    for (int i = 0; i < wr_addr_q.size() && i < exp_addr.size(); i++) begin
      total++;
      if ({wr_addr_q[i], wr_data_q[i]} !== {exp_addr[i], exp_data[i]}) begin
        bad++;
        $display("[TB] FAIL gaps_write%0d: got %h/%h expected %h/%h", i,
                 wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
      end
    end
    for (int i = 1; i < wr_cyc_q.size(); i++) begin
      total++;
      if (wr_cyc_q[i] - wr_cyc_q[i - 1] !== 2) begin
        bad++;
        $display("[TB] FAIL gaps_spacing%0d: got %0d expected 2", i,
                 wr_cyc_q[i] - wr_cyc_q[i - 1]);
      end
    end
    total++;
    if ({done, count} !== {1'b1, 8'd4}) begin
      bad++;
      $display("[TB] FAIL gaps_status: got d%b c%0d expected d1 c4", done, count);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] d0;
    logic [7:0] d1;
    bq_t        b;
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd4;
    @(negedge clk);
    in_data = d0;
    @(negedge clk);
    in_data = d1;
    @(negedge clk);
    reset    = 1'b1;
    in_data  = 8'($urandom);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (wr_addr_q.size() !== 2) begin
      bad++;
      $display("[TB] FAIL midrst_nwrites: got %0d expected 2", wr_addr_q.size());
    end
    total++;
    if (wr_addr_q.size() == 2 &&
        {wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]} !== {8'd0, d0, 8'd1, d1}) begin
      bad++;
      $display("[TB] FAIL midrst_writes: got %h expected %h",
               {wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]}, {8'd0, d0, 8'd1, d1});
    end
    total++;
    if ({busy, cpu_reset, done, error, count} !== {4'b0100, 8'd0}) begin
      bad++;
      $display("[TB] FAIL midrst_status: got b%b r%b d%b e%b c%0d expected b0 r1 d0 e0 c0",
               busy, cpu_reset, done, error, count);
    end
    b = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
    model_session(b);
    drive_session(b, 1'b0);
    total++;
    if ({done, cpu_reset, count} !== {2'b10, 8'd3} || wr_addr_q.size() !== 3) begin
      bad++;
      $display("[TB] FAIL midrst_reload: got d%b r%b c%0d n%0d expected d1 r0 c3 n3",
               done, cpu_reset, count, wr_addr_q.size());
    end
  endtask

  task automatic test_ignored();
    bq_t b;
    int  sum;
    do_reset();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    in_valid = 1'b1;
    repeat (3) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, cpu_reset, count} !== {2'b01, 8'd0} || wr_addr_q.size() !== 0) begin
      bad++;
      $display("[TB] FAIL ign_idle_valid: got b%b r%b c%0d n%0d expected b0 r1 c0 n0",
               busy, cpu_reset, count, wr_addr_q.size());
    end
    b   = '{8'h03};
    sum = 3;
    for (int i = 0; i < 3; i++) begin
      b.push_back(8'($urandom));
      sum = sum + int'(b[i + 1]);
    end
    b.push_back(8'(sum));
    model_session(b);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = b[0];
    @(negedge clk);
    in_data = b[1];
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, count} !== {1'b1, 8'd1}) begin
      bad++;
      $display("[TB] FAIL ign_start_in_data: got b%b c%0d expected b1 c1", busy, count);
    end
    for (int i = 2; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = b[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({done, count} !== {1'b1, exp_count} || wr_addr_q.size() !== 3) begin
      bad++;
      $display("[TB] FAIL ign_start_result: got d%b c%0d n%0d expected d1 c%0d n3",
               done, count, wr_addr_q.size(), exp_count);
    end
    for (int i = 0; i < wr_addr_q.size() && i < exp_addr.size(); i++) begin
      total++;
      if ({wr_addr_q[i], wr_data_q[i]} !== {exp_addr[i], exp_data[i]}) begin
        bad++;
        $display("[TB] FAIL ign_write%0d: got %h/%h expected %h/%h", i,
                 wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
      end
    end
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({done, cpu_reset, count} !== {2'b10, 8'd3} || wr_addr_q.size() !== 3) begin
      bad++;
      $display("[TB] FAIL ign_done_valid: got d%b r%b c%0d n%0d expected d1 r0 c3 n3",
               done, cpu_reset, count, wr_addr_q.size());
    end
  endtask

  // Random sessions back to back, lengths spanning past MAX_LEN so the
  // length check and dropped bytes in ERR are exercised.
  task automatic test_random();
    bq_t b;
    bit  gaps;
    for (int n = 0; n < 25; n++) begin
      build_random(b, int'(TB_MAX_LEN) + 4);
      gaps = 1'($urandom_range(1, 0));
      model_session(b);
      drive_session(b, gaps);
      total++;
      if (wr_addr_q.size() !== exp_addr.size()) begin
        bad++;
        $display("[TB] FAIL rand%0d_nwrites: got %0d expected %0d", n,
                 wr_addr_q.size(), exp_addr.size());
      end
      for (int i = 0; i < wr_addr_q.size() && i < exp_addr.size(); i++) begin
        total++;
        if ({wr_addr_q[i], wr_data_q[i]} !== {exp_addr[i], exp_data[i]}) begin
          bad++;
          $display("[TB] FAIL rand%0d_write%0d: got %h/%h expected %h/%h", n, i,
                   wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
        end
      end
      total++;
      if ({done, error, cpu_reset, busy, count} !==
          {exp_done, exp_error, !exp_done, 1'b0, exp_count}) begin
        bad++;
        $display("[TB] FAIL rand%0d_status: got d%b e%b r%b b%b c%0d expected d%b e%b r%b b0 c%0d",
                 n, done, error, cpu_reset, busy, count,
                 exp_done, exp_error, !exp_done, exp_count);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    $display("[TB] program_loader bench starting");
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_zero_length();
    test_gaps();
    test_reset_mid_load();
    test_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
